// File: rtl/nx_node_loader.sv
// Node loader: turns load/map/signal requests into 32-bit node messages
// and queues them through a 2-entry output FIFO.
package nx_pkg;
  typedef logic [31:0] nx_message_t;
  typedef enum logic {IDLE, BURST} nx_state_t;
endpackage

module nx_node_loader
  import nx_pkg::*;
#(
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int INSTR_WIDTH    = 15,
  parameter int MAX_INSTRS     = 512
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    req_cmd_i,
  input  logic [ADDR_ROW_WIDTH-1:0]     req_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]     req_col_i,
  input  logic [21:0]                   req_payload_i,
  input  logic [$clog2(MAX_INSTRS):0]   req_count_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [INSTR_WIDTH-1:0]        instr_data_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  output nx_message_t                   msg_data_o,
  output logic                          msg_valid_o,
  input  logic                          msg_ready_i,
  output logic                          idle_o,
  output logic                          err_o,
  output logic [15:0]                   sent_count_o
);

  localparam int CW = $clog2(MAX_INSTRS) + 1;
  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_MAP  = 2'd1;
  localparam logic [1:0] CMD_SIG  = 2'd2;
  localparam logic [1:0] CMD_RSV  = 2'd3;

  nx_state_t   state_q, state_d;
  logic [CW-1:0] remaining_q;
  logic [CW-1:0] n_sat;
  logic [3:0]  row_q, col_q;
  nx_message_t mem_q [2];
  logic        wr_q, rd_q;
  logic [1:0]  occ_q;
  logic        alive_q;
  logic        req_fire, instr_fire, pop;
  logic        load_go, push;
  nx_message_t push_data;

  assign req_fire   = req_valid_i & req_ready_o;
  assign instr_fire = instr_valid_i & instr_ready_o;
  assign pop        = msg_valid_o & msg_ready_i;

  assign n_sat = (req_count_i > CW'(MAX_INSTRS))
               ? CW'(MAX_INSTRS) : req_count_i;
  assign load_go = req_fire && (req_cmd_i == CMD_LOAD)
                && (n_sat != '0);

  assign msg_data_o  = mem_q[rd_q];
  assign msg_valid_o = (occ_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load_go) state_d = BURST;
      BURST: if (instr_fire && remaining_q == CW'(1))
               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // alive_q keeps req_ready_o low while reset is held
  always_comb begin
    req_ready_o   = alive_q && (state_q == IDLE)
                 && (occ_q < 2'd2);
    instr_ready_o = (state_q == BURST) && (occ_q < 2'd2);
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    unique case (1'b1)
      instr_fire: begin
        push      = 1'b1;
        push_data = {row_q, col_q, CMD_LOAD,
                     7'd0, 15'(instr_data_i)};
      end
      req_fire && (req_cmd_i == CMD_MAP
                || req_cmd_i == CMD_SIG): begin
        push      = 1'b1;
        push_data = {4'(req_row_i), 4'(req_col_i),
                     req_cmd_i, req_payload_i};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      occ_q        <= 2'd0;
      remaining_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      err_o        <= 1'b0;
      sent_count_o <= '0;
      idle_o       <= 1'b0;
      alive_q      <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q         <= ~rd_q;
        sent_count_o <= sent_count_o + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (load_go) begin
        remaining_q <= n_sat;
        row_q       <= 4'(req_row_i);
        col_q       <= 4'(req_col_i);
      end else if (instr_fire) begin
        remaining_q <= remaining_q - CW'(1);
      end
      if (req_fire && req_cmd_i == CMD_RSV) err_o <= 1'b1;
      idle_o <= (state_q == IDLE) && (occ_q == 2'd0)
             && !push && !load_go;
    end
  end

endmodule

// File: tb/tb_nx_node_loader.sv
// Scoreboard bench for nx_node_loader: directed requests push expected
// messages; a negedge monitor pops and compares each message handshake.
module tb_nx_node_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  req_cmd_i = '0;
  logic [3:0]  req_row_i = '0;
  logic [3:0]  req_col_i = '0;
  logic [21:0] req_payload_i = '0;
  logic [9:0]  req_count_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [14:0] instr_data_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] msg_data_o;
  logic        msg_valid_o;
  logic        msg_ready_i = 1'b1;
  logic        idle_o;
  logic        err_o;
  logic [15:0] sent_count_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  nx_node_loader dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_cmd_i(req_cmd_i), .req_row_i(req_row_i),
    .req_col_i(req_col_i), .req_payload_i(req_payload_i),
    .req_count_i(req_count_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .instr_data_i(instr_data_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .msg_data_o(msg_data_o), .msg_valid_o(msg_valid_o),
    .msg_ready_i(msg_ready_i), .idle_o(idle_o), .err_o(err_o),
    .sent_count_o(sent_count_o)
  );

  function automatic logic [31:0] mk(input logic [3:0] r,
    input logic [3:0] c, input logic [1:0] cmd,
    input logic [21:0] pl);
    return {r, c, cmd, pl};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i && msg_valid_o && msg_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_msg: got %h expected none",
                 msg_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (msg_data_o !== e) begin
          failures++;
          $display("FAIL msg: got %h expected %h", msg_data_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_req(input logic [1:0] cmd,
    input logic [3:0] r, input logic [3:0] c,
    input logic [21:0] pl, input logic [9:0] n,
    input logic [31:0] e, input bit has_msg, output int waited);
    req_cmd_i = cmd; req_row_i = r; req_col_i = c;
    req_payload_i = pl; req_count_i = n; req_valid_i = 1'b1;
    waited = 0;
    while (!req_ready_o && waited < 100) begin
      tick(); waited++;
    end
    if (!req_ready_o) begin
      checks++; failures++;
      $display("FAIL req_timeout: got ready=0 expected ready=1");
      req_valid_i = 1'b0;
      return;
    end
    if (has_msg) exp_q.push_back(e);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic send_instr(input logic [14:0] d,
                            input logic [31:0] e);
    int n = 0;
    instr_data_i = d; instr_valid_i = 1'b1;
    while (!instr_ready_o && n < 100) begin
      tick(); n++;
    end
    if (!instr_ready_o) begin
      checks++; failures++;
      $display("FAIL instr_timeout: got ready=0 expected ready=1");
      instr_valid_i = 1'b0;
      return;
    end
    exp_q.push_back(e);
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || msg_valid_o) && n < 300) begin
      tick(); n++;
    end
    checks++;
    if (exp_q.size() != 0 || msg_valid_o) begin
      failures++;
      $display("FAIL drain_timeout: got pending=%0d expected 0",
               exp_q.size());
    end
  endtask

  initial begin
    int w;
    logic [14:0] ins [3];
    ins[0] = 15'h0001; ins[1] = 15'h7FFF; ins[2] = 15'h1234;

    // reset state
    #12;
    chk("rst_valid", 32'(msg_valid_o), 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    chk("rst_instr_ready", 32'(instr_ready_o), 0);
    chk("rst_idle", 32'(idle_o), 0);
    chk("rst_data", msg_data_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_sent", 32'(sent_count_o), 0);
    tick(); rst_i = 1'b1;
    tick(); tick();
    chk("idle_after_rst", 32'(idle_o), 1);

    // MAP_OUTPUT row 3 col 5
    send_req(2'd1, 4'd3, 4'd5, 22'h2ABCDE, 10'd0,
             32'h356ABCDE, 1'b1, w);
    chk("map_valid_next", 32'(msg_valid_o), 1);
    chk("map_data", msg_data_o, 32'h356ABCDE);
    wait_drain();

    // LOAD_INSTR N=3
    send_req(2'd0, 4'd1, 4'd2, 22'd0, 10'd3, 0, 1'b0, w);
    for (int i = 0; i < 3; i++)
      send_instr(ins[i], mk(4'd1, 4'd2, 2'd0, {7'd0, ins[i]}));
    chk("load_back_idle", 32'(instr_ready_o), 0);
    wait_drain();
    tick();
    chk("load_sent", 32'(sent_count_o), 4);
    chk("load_idle", 32'(idle_o), 1);
    chk("load_req_ready", 32'(req_ready_o), 1);

    // LOAD_INSTR N=0
    send_req(2'd0, 4'd2, 4'd2, 22'd0, 10'd0, 0, 1'b0, w);
    chk("n0_idle", 32'(idle_o), 1);
    chk("n0_instr_ready", 32'(instr_ready_o), 0);
    chk("n0_req_ready", 32'(req_ready_o), 1);
    tick();
    chk("n0_idle_later", 32'(idle_o), 1);
    send_req(2'd2, 4'd7, 4'd1, 22'h000123, 10'd0,
             32'h71800123, 1'b1, w);
    chk("n0_next_wait", 32'(w), 0);
    wait_drain();

    // reserved command
    send_req(2'd3, 4'd5, 4'd5, 22'h3FFFFF, 10'd0, 0, 1'b0, w);
    chk("rsv_err", 32'(err_o), 1);
    chk("rsv_ready", 32'(req_ready_o), 1);
    tick(); tick();
    chk("rsv_no_msg", 32'(msg_valid_o), 0);
    chk("rsv_instr_ready", 32'(instr_ready_o), 0);

    // backpressure during a burst of 4
    msg_ready_i = 1'b0;
    send_req(2'd0, 4'd6, 4'd7, 22'd0, 10'd4, 0, 1'b0, w);
    send_instr(15'h0AAA, 32'h67000AAA);
    send_instr(15'h0BBB, 32'h67000BBB);
    chk("bp_instr_ready", 32'(instr_ready_o), 0);
    chk("bp_head", msg_data_o, 32'h67000AAA);
    repeat (3) tick();
    chk("bp_stable", msg_data_o, 32'h67000AAA);
    chk("bp_valid", 32'(msg_valid_o), 1);
    msg_ready_i = 1'b1;
    send_instr(15'h0CCC, 32'h67000CCC);
    send_instr(15'h0DDD, 32'h67000DDD);
    wait_drain();
    chk("bp_sent", 32'(sent_count_o), 9);
    chk("err_sticky", 32'(err_o), 1);

    // count above MAX_INSTRS saturates at 512
    send_req(2'd0, 4'hF, 4'hE, 22'd0, 10'd600, 0, 1'b0, w);
    for (int i = 0; i < 512; i++)
      send_instr(15'(i), mk(4'hF, 4'hE, 2'd0, 22'(i)));
    chk("sat_instr_ready", 32'(instr_ready_o), 0);
    chk("sat_req_ready", 32'(req_ready_o), 1);
    wait_drain();
    chk("sat_sent", 32'(sent_count_o), 521);

    // reset after 2 of 5 beats
    send_req(2'd0, 4'd4, 4'd8, 22'd0, 10'd5, 0, 1'b0, w);
    send_instr(15'h0011, 32'h48000011);
    send_instr(15'h0022, 32'h48000022);
    wait_drain();
    rst_i = 1'b0;
    #2;
    chk("mrst_valid", 32'(msg_valid_o), 0);
    chk("mrst_req_ready", 32'(req_ready_o), 0);
    chk("mrst_instr_ready", 32'(instr_ready_o), 0);
    chk("mrst_idle", 32'(idle_o), 0);
    chk("mrst_data", msg_data_o, 0);
    chk("mrst_err", 32'(err_o), 0);
    chk("mrst_sent", 32'(sent_count_o), 0);
    exp_q.delete();
    tick(); tick();
    rst_i = 1'b1;
    tick(); tick();
    chk("post_rst_instr_ready", 32'(instr_ready_o), 0);
    chk("post_rst_req_ready", 32'(req_ready_o), 1);
    send_req(2'd2, 4'd9, 4'hA, 22'h155555, 10'd0,
             32'h9A955555, 1'b1, w);
    wait_drain();
    chk("post_rst_sent", 32'(sent_count_o), 1);
    chk("final_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
